lc3_control_fsm: RTL and testbench

Multi-cycle instruction sequencer for the LC-3 datapath. It drives the PC load and select controls (selPC: 0 = PC+1, 1 = eabOut, 2 = Buss), the IR/MAR/MDR/register-file loads, the bus gates, the ALU op and the address-adder selects. It runs fetch/decode/execute with a ready handshake to memory. It sits between the datapath registers and the memory interface.

---
 rtl/lc3_pkg.sv | 60 ++++++
 rtl/lc3_mem_wait.sv | 36 +++
 rtl/lc3_control_fsm.sv | 217 +++++++++++++++++++++
 tb/tb_lc3_control_fsm.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Shared encodings for the LC-3 control sequencer: state codes, opcodes and datapath mux selects.
package lc3_pkg;

  localparam int unsigned StateW   = 5;
  localparam int unsigned WaitCntW = 8;

  localparam logic [StateW-1:0] StIdle   = 5'd0;
  localparam logic [StateW-1:0] StFetch0 = 5'd1;
  localparam logic [StateW-1:0] StFetch1 = 5'd2;
  localparam logic [StateW-1:0] StFetch2 = 5'd3;
  localparam logic [StateW-1:0] StDecode = 5'd4;
  localparam logic [StateW-1:0] StAlu    = 5'd5;
  localparam logic [StateW-1:0] StBr     = 5'd6;
  localparam logic [StateW-1:0] StJmp    = 5'd7;
  localparam logic [StateW-1:0] StJsr    = 5'd8;
  localparam logic [StateW-1:0] StLd0    = 5'd9;
  localparam logic [StateW-1:0] StLd1    = 5'd10;
  localparam logic [StateW-1:0] StLd2    = 5'd11;
  localparam logic [StateW-1:0] StSt0    = 5'd12;
  localparam logic [StateW-1:0] StSt1    = 5'd13;
  localparam logic [StateW-1:0] StSt2    = 5'd14;
  localparam logic [StateW-1:0] StLea    = 5'd15;
  localparam logic [StateW-1:0] StHalt   = 5'd16;
  localparam logic [StateW-1:0] StIll    = 5'd17;
  localparam logic [StateW-1:0] StFault  = 5'd18;

  localparam logic [3:0] OpBr   = 4'b0000;
  localparam logic [3:0] OpAdd  = 4'b0001;
  localparam logic [3:0] OpLd   = 4'b0010;
  localparam logic [3:0] OpSt   = 4'b0011;
  localparam logic [3:0] OpJsr  = 4'b0100;
  localparam logic [3:0] OpAnd  = 4'b0101;
  localparam logic [3:0] OpNot  = 4'b1001;
  localparam logic [3:0] OpJmp  = 4'b1100;
  localparam logic [3:0] OpLea  = 4'b1110;
  localparam logic [3:0] OpTrap = 4'b1111;

  localparam logic [1:0] PcInc = 2'd0;
  localparam logic [1:0] PcEab = 2'd1;
  localparam logic [1:0] PcBus = 2'd2;

  localparam logic [1:0] AluAdd   = 2'd0;
  localparam logic [1:0] AluAnd   = 2'd1;
  localparam logic [1:0] AluNot   = 2'd2;
  localparam logic [1:0] AluPassA = 2'd3;

  localparam logic [1:0] Eab2Zero  = 2'd0;
  localparam logic [1:0] Eab2Off6  = 2'd1;
  localparam logic [1:0] Eab2Off9  = 2'd2;
  localparam logic [1:0] Eab2Off11 = 2'd3;

  function automatic logic [1:0] alu_op(input logic [3:0] opcode);
    case (opcode)
      OpAnd:   return AluAnd;
      OpNot:   return AluNot;
      default: return AluAdd;
    endcase
  endfunction

endpackage

// File: rtl/lc3_mem_wait.sv
// Memory wait-state counter: counts stalled request cycles and flags the final stalled one.
module lc3_mem_wait
  import lc3_pkg::*;
#(
  parameter int unsigned MemTimeout = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic mem_en_i,
  input  logic mem_ready_i,
  output logic timeout_o
);

  localparam logic [WaitCntW-1:0] LastCnt = WaitCntW'(MemTimeout - 1);

  logic [WaitCntW-1:0] cnt_q, cnt_d;

  // Every wait state exits on ready or timeout, so clearing then also covers the
  // "clear on entry" case for the next access.
  always_comb begin
    timeout_o = mem_en_i & ~mem_ready_i & (cnt_q == LastCnt);
    cnt_d     = '0;
    if (mem_en_i && !mem_ready_i && !timeout_o) begin
      cnt_d = cnt_q + WaitCntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lc3_control_fsm.sv
// Multi-cycle LC-3 fetch/decode/execute sequencer; Moore outputs drive the datapath controls.
module lc3_control_fsm
  import lc3_pkg::*;
#(
  parameter int unsigned MemTimeout = 15
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [15:0] ir_i,
  input  logic        n_i,
  input  logic        z_i,
  input  logic        p_i,
  input  logic        mem_ready_i,
  output logic        ld_pc_o,
  output logic [1:0]  sel_pc_o,
  output logic        ld_ir_o,
  output logic        ld_mar_o,
  output logic        ld_mdr_o,
  output logic        ld_reg_o,
  output logic        ld_cc_o,
  output logic        sel_mdr_o,
  output logic        dr_sel_o,
  output logic        sr1_sel_o,
  output logic        gate_pc_o,
  output logic        gate_mdr_o,
  output logic        gate_alu_o,
  output logic        gate_marmux_o,
  output logic [1:0]  aluk_o,
  output logic        sel_eab1_o,
  output logic [1:0]  sel_eab2_o,
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic        halted_o,
  output logic        fault_o,
  output logic        illegal_o,
  output logic [4:0]  state_o
);

  logic [StateW-1:0] state_q, state_d;
  logic [3:0]        opcode;
  logic              br_taken;
  logic              timeout;
  logic              unused_ir;

  assign opcode    = ir_i[15:12];
  assign br_taken  = (ir_i[11] & n_i) | (ir_i[10] & z_i) | (ir_i[9] & p_i);
  assign unused_ir = ^ir_i[8:0];
  assign state_o   = state_q;

  lc3_mem_wait #(
    .MemTimeout(MemTimeout)
  ) u_mem_wait (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .mem_en_i   (mem_en_o),
    .mem_ready_i(mem_ready_i),
    .timeout_o  (timeout)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   state_d = StFetch0;
      StFetch0: state_d = StFetch1;
      StFetch1: begin
        if (timeout) begin
          state_d = StFault;
        end else if (mem_ready_i) begin
          state_d = StFetch2;
        end
      end
      StFetch2: state_d = StDecode;
      StDecode: begin
        case (opcode)
          OpAdd, OpAnd, OpNot: state_d = StAlu;
          OpBr:                state_d = br_taken ? StBr : StFetch0;
          OpJmp:               state_d = StJmp;
          OpJsr:               state_d = StJsr;
          OpLd:                state_d = StLd0;
          OpSt:                state_d = StSt0;
          OpLea:               state_d = StLea;
          OpTrap:              state_d = StHalt;
          default:             state_d = StIll;
        endcase
      end
      StAlu, StBr, StJmp, StJsr, StLd2, StLea, StIll: state_d = StFetch0;
      StLd0: state_d = StLd1;
      StLd1: begin
        if (timeout) begin
          state_d = StFault;
        end else if (mem_ready_i) begin
          state_d = StLd2;
        end
      end
      StSt0: state_d = StSt1;
      StSt1: state_d = StSt2;
      StSt2: begin
        if (timeout) begin
          state_d = StFault;
        end else if (mem_ready_i) begin
          state_d = StFetch0;
        end
      end
      StHalt:  state_d = StHalt;
      StFault: state_d = StFault;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ld_pc_o       = 1'b0;
    sel_pc_o      = PcInc;
    ld_ir_o       = 1'b0;
    ld_mar_o      = 1'b0;
    ld_mdr_o      = 1'b0;
    ld_reg_o      = 1'b0;
    ld_cc_o       = 1'b0;
    sel_mdr_o     = 1'b0;
    dr_sel_o      = 1'b0;
    sr1_sel_o     = 1'b0;
    gate_pc_o     = 1'b0;
    gate_mdr_o    = 1'b0;
    gate_alu_o    = 1'b0;
    gate_marmux_o = 1'b0;
    aluk_o        = AluAdd;
    sel_eab1_o    = 1'b0;
    sel_eab2_o    = Eab2Zero;
    mem_en_o      = 1'b0;
    mem_we_o      = 1'b0;
    halted_o      = 1'b0;
    fault_o       = 1'b0;
    illegal_o     = 1'b0;
    case (state_q)
      StFetch0: begin
        gate_pc_o = 1'b1;
        ld_mar_o  = 1'b1;
        ld_pc_o   = 1'b1;
        sel_pc_o  = PcInc;
      end
      // MDR captures read data only on the completing cycle.
      StFetch1, StLd1: begin
        mem_en_o  = 1'b1;
        ld_mdr_o  = mem_ready_i;
        sel_mdr_o = 1'b0;
      end
      StFetch2: begin
        gate_mdr_o = 1'b1;
        ld_ir_o    = 1'b1;
      end
      StAlu: begin
        gate_alu_o = 1'b1;
        ld_reg_o   = 1'b1;
        ld_cc_o    = 1'b1;
        aluk_o     = alu_op(opcode);
      end
      StBr: begin
        sel_eab2_o = Eab2Off9;
        ld_pc_o    = 1'b1;
        sel_pc_o   = PcEab;
      end
      StJmp: begin
        sel_eab1_o = 1'b1;
        ld_pc_o    = 1'b1;
        sel_pc_o   = PcEab;
      end
      // Old PC goes to R7 on the same edge the PC loads, so JSRR R7 uses the old R7.
      StJsr: begin
        gate_pc_o  = 1'b1;
        ld_reg_o   = 1'b1;
        dr_sel_o   = 1'b1;
        ld_pc_o    = 1'b1;
        sel_pc_o   = PcEab;
        sel_eab1_o = ~ir_i[11];
        sel_eab2_o = ir_i[11] ? Eab2Off11 : Eab2Zero;
      end
      StLd0, StSt0: begin
        sel_eab2_o    = Eab2Off9;
        gate_marmux_o = 1'b1;
        ld_mar_o      = 1'b1;
      end
      StLd2: begin
        gate_mdr_o = 1'b1;
        ld_reg_o   = 1'b1;
        ld_cc_o    = 1'b1;
      end
      StSt1: begin
        sr1_sel_o  = 1'b1;
        aluk_o     = AluPassA;
        gate_alu_o = 1'b1;
        ld_mdr_o   = 1'b1;
        sel_mdr_o  = 1'b1;
      end
      StSt2: begin
        mem_en_o = 1'b1;
        mem_we_o = 1'b1;
      end
      StLea: begin
        sel_eab2_o    = Eab2Off9;
        gate_marmux_o = 1'b1;
        ld_reg_o      = 1'b1;
      end
      StHalt:  halted_o = 1'b1;
      StIll:   illegal_o = 1'b1;
      StFault: fault_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Scoreboard bench for lc3_control_fsm: per-cycle expected output words queued, compared at negedge.
module tb_lc3_control_fsm;
  import lc3_pkg::*;

  localparam logic [18:0] FLdPc   = 19'h00001;
  localparam logic [18:0] FLdIr   = 19'h00002;
  localparam logic [18:0] FLdMar  = 19'h00004;
  localparam logic [18:0] FLdMdr  = 19'h00008;
  localparam logic [18:0] FLdReg  = 19'h00010;
  localparam logic [18:0] FLdCc   = 19'h00020;
  localparam logic [18:0] FSelMdr = 19'h00040;
  localparam logic [18:0] FDrSel  = 19'h00080;
  localparam logic [18:0] FSr1Sel = 19'h00100;
  localparam logic [18:0] FGPc    = 19'h00200;
  localparam logic [18:0] FGMdr   = 19'h00400;
  localparam logic [18:0] FGAlu   = 19'h00800;
  localparam logic [18:0] FGMm    = 19'h01000;
  localparam logic [18:0] FEab1   = 19'h02000;
  localparam logic [18:0] FMemEn  = 19'h04000;
  localparam logic [18:0] FMemWe  = 19'h08000;
  localparam logic [18:0] FHalt   = 19'h10000;
  localparam logic [18:0] FFault  = 19'h20000;
  localparam logic [18:0] FIll    = 19'h40000;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  logic        clk, rst_n, n, z, p, mem_ready;
  logic [15:0] ir;
  logic        ld_pc, ld_ir, ld_mar, ld_mdr, ld_reg, ld_cc, sel_mdr, dr_sel, sr1_sel;
  logic        gate_pc, gate_mdr, gate_alu, gate_marmux, sel_eab1, mem_en, mem_we;
  logic        halted, fault, illegal;
  logic [1:0]  sel_pc, aluk, sel_eab2;
  logic [4:0]  state;
  logic [31:0] obs;
  sb_t         sb[$];
  int          n_checks = 0;
  int          n_fails  = 0;

  lc3_control_fsm #(
    .MemTimeout(4)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .ir_i         (ir),
    .n_i          (n),
    .z_i          (z),
    .p_i          (p),
    .mem_ready_i  (mem_ready),
    .ld_pc_o      (ld_pc),
    .sel_pc_o     (sel_pc),
    .ld_ir_o      (ld_ir),
    .ld_mar_o     (ld_mar),
    .ld_mdr_o     (ld_mdr),
    .ld_reg_o     (ld_reg),
    .ld_cc_o      (ld_cc),
    .sel_mdr_o    (sel_mdr),
    .dr_sel_o     (dr_sel),
    .sr1_sel_o    (sr1_sel),
    .gate_pc_o    (gate_pc),
    .gate_mdr_o   (gate_mdr),
    .gate_alu_o   (gate_alu),
    .gate_marmux_o(gate_marmux),
    .aluk_o       (aluk),
    .sel_eab1_o   (sel_eab1),
    .sel_eab2_o   (sel_eab2),
    .mem_en_o     (mem_en),
    .mem_we_o     (mem_we),
    .halted_o     (halted),
    .fault_o      (fault),
    .illegal_o    (illegal),
    .state_o      (state)
  );

  assign obs = {2'b00, state, sel_eab2, aluk, sel_pc, illegal, fault, halted, mem_we, mem_en,
                sel_eab1, gate_marmux, gate_alu, gate_mdr, gate_pc, sr1_sel, dr_sel, sel_mdr,
                ld_cc, ld_reg, ld_mdr, ld_mar, ld_ir, ld_pc};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] w(input logic [4:0] s, input logic [1:0] pcs,
                                    input logic [1:0] ak, input logic [1:0] e2,
                                    input logic [18:0] flags);
    return {2'b00, s, e2, ak, pcs, flags};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      sb_t item;
      item = sb.pop_front();
      check(item.tag, obs, item.exp);
    end
  end

  task automatic cycle(input string tag, input logic mr, input logic [31:0] e);
    sb_t item;
    @(posedge clk);
    #1;
    mem_ready = mr;
    item.tag  = tag;
    item.exp  = e;
    sb.push_back(item);
  endtask

  // Asserts reset mid-cycle after the pending compare, checks outputs drop at once, holds a cycle.
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check(tag, obs, 32'h0);
    cycle({tag, "_idle"}, 1'b0, w(StIdle, 0, 0, 0, 0));
    rst_n = 1'b1;
  endtask

  task automatic fetch(input string tag, input logic [15:0] instr, input logic [2:0] nzp);
    cycle({tag, "_f0"}, 1'b1, w(StFetch0, PcInc, 0, 0, FGPc | FLdMar | FLdPc));
    ir        = instr;
    {n, z, p} = nzp;
    cycle({tag, "_f1"}, 1'b1, w(StFetch1, 0, 0, 0, FMemEn | FLdMdr));
    cycle({tag, "_f2"}, 1'b1, w(StFetch2, 0, 0, 0, FGMdr | FLdIr));
    cycle({tag, "_dec"}, 1'b1, w(StDecode, 0, 0, 0, 0));
  endtask

  initial begin
    rst_n = 1'b0;
    ir = 16'h0;
    {n, z, p} = 3'b000;
    mem_ready = 1'b0;
    pulse_reset("reset");

    fetch("add", 16'h1042, 3'b000);
    cycle("add_exec", 1'b1, w(StAlu, 0, AluAdd, 0, FGAlu | FLdReg | FLdCc));
    fetch("and", 16'h5042, 3'b000);
    cycle("and_exec", 1'b1, w(StAlu, 0, AluAnd, 0, FGAlu | FLdReg | FLdCc));
    fetch("not", 16'h907F, 3'b000);
    cycle("not_exec", 1'b1, w(StAlu, 0, AluNot, 0, FGAlu | FLdReg | FLdCc));

    fetch("brnp_z", 16'h0A05, 3'b010);
    fetch("brnp_n", 16'h0A05, 3'b100);
    cycle("br_taken", 1'b1, w(StBr, PcEab, 0, Eab2Off9, FLdPc));

    fetch("jsrr", 16'h4005, 3'b000);
    cycle("jsrr_exec", 1'b1, w(StJsr, PcEab, 0, Eab2Zero, FGPc | FLdReg | FDrSel | FLdPc | FEab1));
    fetch("jsr", 16'h4805, 3'b000);
    cycle("jsr_exec", 1'b1, w(StJsr, PcEab, 0, Eab2Off11, FGPc | FLdReg | FDrSel | FLdPc));
    fetch("jmp", 16'hC080, 3'b000);
    cycle("jmp_exec", 1'b1, w(StJmp, PcEab, 0, Eab2Zero, FLdPc | FEab1));
    fetch("lea", 16'hE005, 3'b000);
    cycle("lea_exec", 1'b1, w(StLea, 0, 0, Eab2Off9, FGMm | FLdReg));

    // Ready arrives on the last allowed wait cycle and must win over the timeout.
    fetch("st", 16'h3201, 3'b000);
    cycle("st0", 1'b1, w(StSt0, 0, 0, Eab2Off9, FGMm | FLdMar));
    cycle("st1", 1'b1, w(StSt1, 0, AluPassA, 0, FSr1Sel | FGAlu | FLdMdr | FSelMdr));
    for (int i = 0; i < 3; i++) begin
      cycle($sformatf("st2_wait%0d", i), 1'b0, w(StSt2, 0, 0, 0, FMemEn | FMemWe));
    end
    cycle("st2_done", 1'b1, w(StSt2, 0, 0, 0, FMemEn | FMemWe));

    fetch("ld", 16'h2005, 3'b000);
    cycle("ld0", 1'b1, w(StLd0, 0, 0, Eab2Off9, FGMm | FLdMar));
    cycle("ld1_wait", 1'b0, w(StLd1, 0, 0, 0, FMemEn));
    cycle("ld1_done", 1'b1, w(StLd1, 0, 0, 0, FMemEn | FLdMdr));
    cycle("ld2", 1'b1, w(StLd2, 0, 0, 0, FGMdr | FLdReg | FLdCc));

    fetch("ill", 16'hD000, 3'b000);
    cycle("ill_exec", 1'b0, w(StIll, 0, 0, 0, FIll));

    cycle("to_f0", 1'b0, w(StFetch0, PcInc, 0, 0, FGPc | FLdMar | FLdPc));
    for (int i = 0; i < 4; i++) begin
      cycle($sformatf("to_f1_wait%0d", i), 1'b0, w(StFetch1, 0, 0, 0, FMemEn));
    end
    for (int i = 0; i < 3; i++) begin
      cycle($sformatf("fault%0d", i), 1'b1, w(StFault, 0, 0, 0, FFault));
    end
    pulse_reset("fault_reset");

    fetch("halt", 16'hF025, 3'b000);
    for (int i = 0; i < 3; i++) begin
      cycle($sformatf("halt%0d", i), 1'b1, w(StHalt, 0, 0, 0, FHalt));
    end
    pulse_reset("halt_reset");

    fetch("ld_rst", 16'h2005, 3'b000);
    cycle("ld_rst_ld0", 1'b1, w(StLd0, 0, 0, Eab2Off9, FGMm | FLdMar));
    cycle("ld_rst_ld1", 1'b0, w(StLd1, 0, 0, 0, FMemEn));
    pulse_reset("ld1_reset");
    fetch("restart", 16'h1042, 3'b000);
    cycle("restart_exec", 1'b1, w(StAlu, 0, AluAdd, 0, FGAlu | FLdReg | FLdCc));

    @(negedge clk);
    #1;
    check("sb_drain", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
